seq_detector_mealy: RTL and testbench

- Parametrised, programmable serial bit-pattern detector built as a registered-output Mealy machine.
- Samples one serial bit per enabled clock and pulses `out` when the last PAT_W bits equal the loaded pattern.
- Supports overlapping and non-overlapping detection and keeps a saturating match counter.
- Used wherever the design needs framing, sync-word or command detection on a 1-bit stream.

---
 rtl/seq_detector_mealy.sv | 93 +++++++++
 tb/tb_seq_detector_mealy.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seq_detector_mealy.sv
// Programmable serial pattern detector: registered-output Mealy machine with
// overlap/non-overlap modes, a valid-bit fill counter and a saturating match count.
module seq_detector_mealy #(
  parameter int unsigned          PAT_W   = 4,
  parameter int unsigned          CNT_W   = 8,
  parameter logic [PAT_W-1:0]     RST_PAT = 4'b1011
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          en,
  input  logic                          inp,
  input  logic                          overlap,
  input  logic                          pat_load,
  input  logic [PAT_W-1:0]              pattern,
  input  logic                          clr_count,
  output logic                          out,
  output logic [CNT_W-1:0]              match_count,
  output logic [$clog2(PAT_W+1)-1:0]    fill
);

  localparam int unsigned       FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [PAT_W-1:0]  r_pat;
  logic [PAT_W-1:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic              r_out;
  logic [CNT_W-1:0]  r_count;

  logic [PAT_W-1:0]  w_win;
  logic [FILL_W-1:0] w_fill_nx;
  logic              w_match;

  // Window as it would look after shifting in the current bit, and whether it matches
  always_comb begin
    w_win     = {r_hist[PAT_W-2:0], inp};
    w_fill_nx = r_fill;
    w_match   = 1'b0;
    if (r_fill == FILL_FULL) begin
      w_fill_nx = r_fill;
    end else begin
      w_fill_nx = r_fill + FILL_W'(1);
    end
    if (en && !pat_load && (w_fill_nx == FILL_FULL) && (w_win == r_pat)) begin
      w_match = 1'b1;
    end else begin
      w_match = 1'b0;
    end
  end

  // Pattern/history/fill/out state plus the saturating match counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pat   <= RST_PAT;
      r_hist  <= '0;
      r_fill  <= '0;
      r_out   <= 1'b0;
      r_count <= '0;
    end else begin
      // Clear wins over a simultaneous match; the match still pulses out below
      if (clr_count) begin
        r_count <= '0;
      end else if (w_match && (r_count != CNT_MAX)) begin
        r_count <= r_count + CNT_W'(1);
      end else begin
        r_count <= r_count;
      end

      if (pat_load) begin
        r_pat  <= pattern;
        r_hist <= '0;
        r_fill <= '0;
        r_out  <= 1'b0;
      end else if (en) begin
        r_hist <= w_win;
        r_out  <= w_match;
        if (w_match && !overlap) begin
          r_fill <= '0;
        end else begin
          r_fill <= w_fill_nx;
        end
      end else begin
        r_out <= 1'b0;
      end
    end
  end

  assign out         = r_out;
  assign match_count = r_count;
  assign fill        = r_fill;

endmodule

// File: tb/tb_seq_detector_mealy.sv
// Bench for seq_detector_mealy: directed scenarios plus randomized traffic,
// all checked against a queue-based model of the last received bits.
module tb_seq_detector_mealy;

  localparam int PAT_W   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = 3;

  logic             clk;
  logic             reset_n;
  logic             en;
  logic             inp;
  logic             overlap;
  logic             pat_load;
  logic [PAT_W-1:0] pattern;
  logic             clr_count;
  logic             out;
  logic [CNT_W-1:0] match_count;
  logic [2:0]       fill;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  bit               m_bits[$];
  logic [PAT_W-1:0] m_pat;
  int               m_count;
  int               m_out;

  seq_detector_mealy #(.PAT_W(PAT_W), .CNT_W(CNT_W), .RST_PAT(4'b1011)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .inp(inp), .overlap(overlap),
    .pat_load(pat_load), .pattern(pattern), .clr_count(clr_count),
    .out(out), .match_count(match_count), .fill(fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_bits.delete();
    m_pat   = 4'b1011;
    m_count = 0;
    m_out   = 0;
  endfunction

  // Does the held history spell the pattern, MSB first?
  function automatic bit model_hit();
    if (m_bits.size() != PAT_W) return 1'b0;
    for (int i = 0; i < PAT_W; i++)
      if (m_bits[i] != m_pat[PAT_W-1-i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_out"},  int'(out),         m_out);
    check({tag, "_fill"}, int'(fill),        m_bits.size());
    check({tag, "_cnt"},  int'(match_count), m_count);
  endtask

  // Drive one cycle, advance the model, then compare just after the edge
  task automatic step(input logic e, input logic b, input logic ov,
                      input logic ld, input logic [PAT_W-1:0] p, input logic clr,
                      input string tag);
    bit hit;
    en = e; inp = b; overlap = ov; pat_load = ld; pattern = p; clr_count = clr;
    hit = 1'b0;
    if (ld) begin
      m_pat = p;
      m_bits.delete();
      m_out = 0;
    end else if (e) begin
      m_bits.push_back(b);
      if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
      hit   = model_hit();
      m_out = hit;
      if (hit && !ov) m_bits.delete();
    end else begin
      m_out = 0;
    end
    if (clr) m_count = 0;
    else if (hit && m_count < CNT_MAX) m_count++;
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic async_reset(input string tag);
    reset_n = 1'b0;
    #2;
    model_reset();
    check_state(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic feed(input int n, input logic [15:0] bits, input logic ov, input string tag);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], ov, 1'b0, 4'b0000, 1'b0, tag);
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b0; inp = 1'b0; overlap = 1'b0;
    pat_load = 1'b0; pattern = '0; clr_count = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // overlapping: 1011011 matches after bits 4 and 7
    feed(7, 16'b1011011, 1'b1, "ovl");
    check("ovl_cnt_end", int'(match_count), 2);
    check("ovl_fill_end", int'(fill), 4);

    // non-overlapping: single match, three fresh bits afterwards
    async_reset("rst2");
    feed(7, 16'b1011011, 1'b0, "novl");
    check("novl_cnt_end", int'(match_count), 1);
    check("novl_fill_end", int'(fill), 3);

    // load 1111 and feed eight 1s with enable holes
    async_reset("rst3");
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'b1111, 1'b0, "load");
    for (int i = 0; i < 16; i++)
      step(~i[0], 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, "hold");
    check("hold_cnt_end", int'(match_count), 2);

    // saturation at 3, then clear on a matching cycle
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, "load0");
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, "sat");
    check("sat_cnt_end", int'(match_count), 3);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, "clr");
    check("clr_out", int'(out), 1);
    check("clr_cnt", int'(match_count), 0);

    // reset mid-stream, then a pulse in progress killed by reset
    async_reset("rst4");
    feed(3, 16'b101, 1'b1, "pre");
    async_reset("mid");
    feed(6, 16'b111011, 1'b1, "post");
    check("post_cnt", int'(match_count), 1);
    check("post_out", int'(out), 1);
    async_reset("kill");
    check("kill_out", int'(out), 0);

    // back-to-back overlapping matches of 1010
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1010, 1'b0, "load1010");
    feed(6, 16'b101010, 1'b1, "b2b");
    check("b2b_cnt", int'(match_count), 2);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic e, b, ov, ld, clr;
      logic [PAT_W-1:0] p;
      e   = ($urandom_range(3) != 0);
      b   = $urandom_range(1);
      ov  = $urandom_range(1);
      ld  = ($urandom_range(39) == 0);
      clr = ($urandom_range(24) == 0);
      p   = PAT_W'($urandom_range(15));
      if ($urandom_range(149) == 0) async_reset("rnd_rst");
      else step(e, b, ov, ld, p, clr, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
